// File: rtl/univ_shift_reg.sv
// univ_shift_reg
// ----------------------------------------------------------------------------
// Parametrised universal shift register. Holds a WIDTH-bit word and supports
// hold, parallel load, logical shift left/right, rotate left/right, arithmetic
// shift right and synchronous clear. Every output is registered, and q_bar is
// registered alongside q so it never lags or glitches relative to q.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   en         operation enable (0 = hold everything, done low)
//   mode       operation select:
//                000 hold  001 load  010 shl  011 shr
//                100 rotl  101 rotr  110 asr  111 clear
//   d          parallel load data
//   sin_l      serial bit entering bit 0 on shl
//   sin_r      serial bit entering bit WIDTH-1 on shr
//   q          register contents
//   q_bar      registered complement of q
//   sout       last bit shifted or rotated out
//   shift_cnt  shifts since last load/clear, saturating at WIDTH
//   done       one-cycle pulse after the shift that brings shift_cnt to WIDTH
//   parity     ^q, registered (only with UNIV_SHIFT_REG_PARITY_EN defined)
//
// Build option
//   UNIV_SHIFT_REG_PARITY_EN  adds the registered parity output.
// ----------------------------------------------------------------------------
module univ_shift_reg #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [2:0]                 mode,
  input  logic [WIDTH-1:0]           d,
  input  logic                       sin_l,
  input  logic                       sin_r,
  output logic [WIDTH-1:0]           q,
  output logic [WIDTH-1:0]           q_bar,
  output logic                       sout,
  output logic [$clog2(WIDTH+1)-1:0] shift_cnt,
  output logic                       done
`ifdef UNIV_SHIFT_REG_PARITY_EN
  ,
  output logic                       parity
`endif
);

  localparam int              CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   CNT_MAX  = CW'(WIDTH);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_LOAD  = 3'b001;
  localparam logic [2:0] MODE_SHL   = 3'b010;
  localparam logic [2:0] MODE_SHR   = 3'b011;
  localparam logic [2:0] MODE_ROTL  = 3'b100;
  localparam logic [2:0] MODE_ROTR  = 3'b101;
  localparam logic [2:0] MODE_ASR   = 3'b110;
  localparam logic [2:0] MODE_CLEAR = 3'b111;

  logic [WIDTH-1:0] q_nxt;
  logic             sout_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic             done_nxt;
  logic             is_shift;

  always_comb begin
    q_nxt    = q;
    sout_nxt = sout;
    cnt_nxt  = shift_cnt;
    done_nxt = 1'b0;
    is_shift = 1'b0;

    if (en) begin
      case (mode)
        MODE_HOLD: begin
        end
        MODE_LOAD: begin
          q_nxt   = d;
          cnt_nxt = '0;
        end
        MODE_SHL: begin
          q_nxt    = {q[WIDTH-2:0], sin_l};
          sout_nxt = q[WIDTH-1];
          is_shift = 1'b1;
        end
        MODE_SHR: begin
          q_nxt    = {sin_r, q[WIDTH-1:1]};
          sout_nxt = q[0];
          is_shift = 1'b1;
        end
        MODE_ROTL: begin
          q_nxt    = {q[WIDTH-2:0], q[WIDTH-1]};
          sout_nxt = q[WIDTH-1];
          is_shift = 1'b1;
        end
        MODE_ROTR: begin
          q_nxt    = {q[0], q[WIDTH-1:1]};
          sout_nxt = q[0];
          is_shift = 1'b1;
        end
        MODE_ASR: begin
          q_nxt    = {q[WIDTH-1], q[WIDTH-1:1]};
          sout_nxt = q[0];
          is_shift = 1'b1;
        end
        MODE_CLEAR: begin
          q_nxt    = '0;
          sout_nxt = 1'b0;
          cnt_nxt  = '0;
        end
        default: begin
        end
      endcase

      // done fires only on the WIDTH-1 -> WIDTH transition; once saturated the
      // count is frozen so the pulse cannot repeat until a load/clear rearms it.
      if (is_shift) begin
        if (shift_cnt == CNT_LAST) done_nxt = 1'b1;
        if (shift_cnt != CNT_MAX)  cnt_nxt  = shift_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q         <= RESET_VAL;
      q_bar     <= ~RESET_VAL;
      sout      <= 1'b0;
      shift_cnt <= '0;
      done      <= 1'b0;
    end else begin
      q         <= q_nxt;
      q_bar     <= ~q_nxt;
      sout      <= sout_nxt;
      shift_cnt <= cnt_nxt;
      done      <= done_nxt;
    end
  end

`ifdef UNIV_SHIFT_REG_PARITY_EN
  // Computed from the next-state word so parity lands on the same edge as q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity <= ^RESET_VAL;
    else        parity <= ^q_nxt;
  end
`endif

endmodule

// File: tb/tb_univ_shift_reg.sv
module tb_univ_shift_reg;

  localparam int             W  = 8;
  localparam int             CW = $clog2(W + 1);
  localparam logic [W-1:0]   RV = 8'hA5;
`ifdef UNIV_SHIFT_REG_PARITY_EN
  localparam int PW = 1;
`else
  localparam int PW = 0;
`endif
  localparam int OW = 2 * W + 1 + CW + 1 + PW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [2:0]    mode;
  logic [W-1:0]  d;
  logic          sin_l;
  logic          sin_r;
  logic [W-1:0]  q;
  logic [W-1:0]  q_bar;
  logic          sout;
  logic [CW-1:0] shift_cnt;
  logic          done;
`ifdef UNIV_SHIFT_REG_PARITY_EN
  logic          parity;
`endif

  int compared   = 0;
  int mismatched = 0;

  // reference model state
  logic [W-1:0]  m_q;
  logic          m_sout;
  logic [CW-1:0] m_cnt;
  logic          m_done;

  logic [OW-1:0] exp_q[$];

  univ_shift_reg #(.WIDTH(W), .RESET_VAL(RV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .mode      (mode),
    .d         (d),
    .sin_l     (sin_l),
    .sin_r     (sin_r),
    .q         (q),
    .q_bar     (q_bar),
    .sout      (sout),
    .shift_cnt (shift_cnt),
    .done      (done)
`ifdef UNIV_SHIFT_REG_PARITY_EN
    ,
    .parity    (parity)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [OW-1:0] pack_obs();
`ifdef UNIV_SHIFT_REG_PARITY_EN
    return {q, q_bar, sout, shift_cnt, done, parity};
`else
    return {q, q_bar, sout, shift_cnt, done};
`endif
  endfunction

  function automatic logic [OW-1:0] pack_exp();
`ifdef UNIV_SHIFT_REG_PARITY_EN
    return {m_q, ~m_q, m_sout, m_cnt, m_done, ^m_q};
`else
    return {m_q, ~m_q, m_sout, m_cnt, m_done};
`endif
  endfunction

  task automatic model_reset();
    m_q    = RV;
    m_sout = 1'b0;
    m_cnt  = '0;
    m_done = 1'b0;
    exp_q.delete();
  endtask

  // Drive one operation, push the model's prediction, and advance to 1 time
  // unit past the edge where the result becomes visible.
  task automatic drive(input logic e, input logic [2:0] m, input logic [W-1:0] dd,
                       input logic sl, input logic sr);
    logic [W-1:0] old;
    en = e; mode = m; d = dd; sin_l = sl; sin_r = sr;
    old    = m_q;
    m_done = 1'b0;
    if (e) begin
      case (m)
        3'd1: begin m_q = dd; m_cnt = '0; end
        3'd2: begin m_q = old << 1;  m_q[0] = sl;         m_sout = old[W-1]; end
        3'd3: begin m_q = old >> 1;  m_q[W-1] = sr;       m_sout = old[0];   end
        3'd4: begin m_q = old << 1;  m_q[0] = old[W-1];   m_sout = old[W-1]; end
        3'd5: begin m_q = old >> 1;  m_q[W-1] = old[0];   m_sout = old[0];   end
        3'd6: begin m_q = W'($signed(old) >>> 1);         m_sout = old[0];   end
        3'd7: begin m_q = '0; m_sout = 1'b0; m_cnt = '0; end
        default: ;
      endcase
      if (m >= 3'd2 && m <= 3'd6) begin
        if (int'(m_cnt) == W - 1) m_done = 1'b1;
        if (int'(m_cnt) < W) m_cnt = m_cnt + CW'(1);
      end
    end
    exp_q.push_back(pack_exp());
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [OW-1:0] got, exp;
    rst_n = 1'b1; en = 1'b0; mode = 3'd0; d = '0; sin_l = 1'b0; sin_r = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    compared++;
    if ({q, q_bar, sout, shift_cnt, done} !== {8'hA5, 8'h5A, 1'b0, 4'd0, 1'b0}) begin
      mismatched++;
      $display("FAIL reset_values: got q=%h q_bar=%h sout=%b cnt=%0d done=%b want A5 5A 0 0 0",
               q, q_bar, sout, shift_cnt, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    drive(1'b1, 3'd0, 8'h00, 1'b0, 1'b0);
    got = pack_obs(); exp = exp_q.pop_front();
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL reset_hold: got %h want %h", got, exp);
    end
  endtask

  task automatic test_shl();
    logic [OW-1:0] got, exp;
    logic [W-1:0]  plan_q[8]  = '{8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'hFF};
    logic          plan_s[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    drive(1'b1, 3'd1, 8'h81, 1'b0, 1'b0);
    got = pack_obs(); exp = exp_q.pop_front();
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL shl_load: got %h want %h", got, exp);
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 3'd2, 8'h00, 1'b1, 1'b0);
      got = pack_obs(); exp = exp_q.pop_front();
      compared++;
      if (got !== exp) begin
        mismatched++;
        $display("FAIL shl_step%0d: got %h want %h", i, got, exp);
      end
      if (i < 8) begin
        compared++;
        if ({q, sout, shift_cnt, done} !== {plan_q[i], plan_s[i], CW'(i + 1), (i == 7)}) begin
          mismatched++;
          $display("FAIL shl_plan%0d: got q=%h sout=%b cnt=%0d done=%b want q=%h sout=%b cnt=%0d done=%b",
                   i, q, sout, shift_cnt, done, plan_q[i], plan_s[i], i + 1, (i == 7));
        end
      end else begin
        compared++;
        if ({q, shift_cnt, done} !== {8'hFF, 4'd8, 1'b0}) begin
          mismatched++;
          $display("FAIL shl_saturate%0d: got q=%h cnt=%0d done=%b want FF 8 0",
                   i, q, shift_cnt, done);
        end
      end
    end
  endtask

  task automatic test_rotate();
    logic [OW-1:0] got, exp;
    drive(1'b1, 3'd1, 8'h01, 1'b0, 1'b0);
    void'(exp_q.pop_front());
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, (i < 3) ? 3'd5 : 3'd4, 8'h00, 1'b1, 1'b1);
      got = pack_obs(); exp = exp_q.pop_front();
      compared++;
      if (got !== exp) begin
        mismatched++;
        $display("FAIL rotate_step%0d: got %h want %h", i, got, exp);
      end
      if (i == 2) begin
        compared++;
        if ({q, sout} !== {8'h20, 1'b0}) begin
          mismatched++;
          $display("FAIL rotr_plan: got q=%h sout=%b want 20 0", q, sout);
        end
      end
    end
    compared++;
    if ({q, shift_cnt, done} !== {8'h01, 4'd6, 1'b0}) begin
      mismatched++;
      $display("FAIL rotl_plan: got q=%h cnt=%0d done=%b want 01 6 0", q, shift_cnt, done);
    end
  endtask

  task automatic test_asr_and_enable();
    logic [OW-1:0] got, exp;
    logic [2:0]    seq[3] = '{3'd6, 3'd6, 3'd3};
    drive(1'b1, 3'd1, 8'h90, 1'b1, 1'b1);
    void'(exp_q.pop_front());
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, seq[i], 8'h00, 1'b1, 1'b0);
      got = pack_obs(); exp = exp_q.pop_front();
      compared++;
      if (got !== exp) begin
        mismatched++;
        $display("FAIL asr_step%0d: got %h want %h", i, got, exp);
      end
      if (i == 1) begin
        compared++;
        if ({q, sout} !== {8'hE4, 1'b0}) begin
          mismatched++;
          $display("FAIL asr_plan: got q=%h sout=%b want E4 0", q, sout);
        end
      end
    end
    compared++;
    if ({q, sout} !== {8'h72, 1'b0}) begin
      mismatched++;
      $display("FAIL shr_plan: got q=%h sout=%b want 72 0", q, sout);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 3'd2, 8'hFF, 1'b1, 1'b1);
      got = pack_obs(); exp = exp_q.pop_front();
      compared++;
      if (got !== exp || {q, shift_cnt, done} !== {8'h72, 4'd3, 1'b0}) begin
        mismatched++;
        $display("FAIL en_low%0d: got %h want %h", i, got, exp);
      end
    end
    drive(1'b1, 3'd7, 8'hFF, 1'b1, 1'b1);
    got = pack_obs(); exp = exp_q.pop_front();
    compared++;
    if (got !== exp || {q, q_bar, shift_cnt} !== {8'h00, 8'hFF, 4'd0}) begin
      mismatched++;
      $display("FAIL clear: got %h want %h", got, exp);
    end
  endtask

  // Reset asserted during the cycle done is visible must kill done at once.
  task automatic test_reset_during_done();
    drive(1'b1, 3'd1, 8'h3C, 1'b0, 1'b0);
    void'(exp_q.pop_front());
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 3'd3, 8'h00, 1'b0, 1'b1);
      void'(exp_q.pop_front());
    end
    compared++;
    if (done !== 1'b1) begin
      mismatched++;
      $display("FAIL done_before_reset: got done=%b want 1", done);
    end
    #2;
    rst_n = 1'b0;
    #1;
    compared++;
    if ({q, q_bar, sout, shift_cnt, done} !== {8'hA5, 8'h5A, 1'b0, 4'd0, 1'b0}) begin
      mismatched++;
      $display("FAIL reset_mid_done: got q=%h q_bar=%h sout=%b cnt=%0d done=%b want A5 5A 0 0 0",
               q, q_bar, sout, shift_cnt, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_back_to_back();
    logic [OW-1:0] got, exp;
    logic [2:0]    ops[8] = '{3'd1, 3'd4, 3'd1, 3'd2, 3'd6, 3'd7, 3'd3, 3'd5};
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, ops[i], W'($urandom), 1'($urandom), 1'($urandom));
      got = pack_obs(); exp = exp_q.pop_front();
      compared++;
      if (got !== exp) begin
        mismatched++;
        $display("FAIL b2b_step%0d: got %h want %h", i, got, exp);
      end
    end
  endtask

`ifdef UNIV_SHIFT_REG_PARITY_EN
  task automatic test_parity();
    logic pl[3] = '{1'b1, 1'b1, 1'b0};
    logic [2:0] ops[3] = '{3'd1, 3'd2, 3'd7};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, ops[i], 8'h07, 1'b0, 1'b0);
      void'(exp_q.pop_front());
      compared++;
      if (parity !== pl[i]) begin
        mismatched++;
        $display("FAIL parity_step%0d: got %b want %b", i, parity, pl[i]);
      end
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 3'd0; d = '0; sin_l = 1'b0; sin_r = 1'b0;
    model_reset();
    test_reset();
    test_shl();
    test_rotate();
    test_asr_and_enable();
    test_reset_during_done();
    test_back_to_back();
`ifdef UNIV_SHIFT_REG_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
